// File: rtl/seg7_pkg.sv
// Shared constants and types for the 7-segment display blocks.
// Segment patterns are active low: [7:1] = a..g, [0] = dp.
package seg7_pkg;

  localparam logic [7:0] SEG_OFF  = 8'hFF;
  localparam logic [7:0] SEG_DASH = 8'hFD;

  localparam logic [7:0] HEX_TABLE [16] = '{
    8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
    8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71
  };

  typedef enum logic {
    GAP,
    DRIVE
  } state_e;

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational nibble to active-low 7-segment pattern (dp bit left off).
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [7:0] pattern_o
);

  assign pattern_o = HEX_TABLE[nibble_i];

endmodule

// File: rtl/seg7_scan.sv
// Time-multiplexed N-digit common-anode 7-segment driver with per-slot dead time,
// per-digit dp/blank/blink and a global '-' mask mode.
module seg7_scan
  import seg7_pkg::*;
#(
  parameter int unsigned N_DIGITS    = 4,
  parameter int unsigned CLK_DIV     = 50000,
  parameter int unsigned GAP_CYCLES  = 500,
  parameter int unsigned BLINK_SLOTS = 1000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*N_DIGITS-1:0] digits_in,
  input  logic [N_DIGITS-1:0]   dp_in,
  input  logic [N_DIGITS-1:0]   blank_in,
  input  logic [N_DIGITS-1:0]   blink_in,
  input  logic                  mask_in,
  input  logic                  en_in,
  output logic [7:0]            seg_out,
  output logic [N_DIGITS-1:0]   an_out
);

  localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int unsigned BW = (BLINK_SLOTS > 1) ? $clog2(BLINK_SLOTS) : 1;

  logic [CW-1:0] cnt_q;
  logic [IW-1:0] idx_q;
  logic [BW-1:0] blink_cnt_q;
  logic          blink_phase_q;

  logic [3:0] snap_nib_q;
  logic       snap_dp_q, snap_blank_q, snap_blink_q;

  logic [3:0] cur_nib, eff_nib;
  logic       cur_dp, cur_blank, cur_blink;
  logic       eff_dp, eff_blank, eff_blink;
  logic       slot_start, slot_end;
  logic [7:0] hex_pat, pattern;
  state_e     state;

  always_comb begin
    cur_nib   = 4'h0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    cur_blink = 1'b0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        cur_nib   = digits_in[4*i +: 4];
        cur_dp    = dp_in[i];
        cur_blank = blank_in[i];
        cur_blink = blink_in[i];
      end
    end
  end

  assign slot_start = (cnt_q == '0);
  assign slot_end   = (cnt_q == CW'(CLK_DIV - 1));

  // On the snapshot cycle itself use the live inputs so a zero-gap slot still drives correctly.
  assign eff_nib   = slot_start ? cur_nib   : snap_nib_q;
  assign eff_dp    = slot_start ? cur_dp    : snap_dp_q;
  assign eff_blank = slot_start ? cur_blank : snap_blank_q;
  assign eff_blink = slot_start ? cur_blink : snap_blink_q;

  assign state = (32'(cnt_q) < GAP_CYCLES) ? GAP : DRIVE;

  seg7_hex_decode u_hex_decode (
    .nibble_i  (eff_nib),
    .pattern_o (hex_pat)
  );

  always_comb begin
    pattern = SEG_OFF;
    if (eff_blank || (eff_blink && blink_phase_q)) begin
      pattern = SEG_OFF;
    end else if (mask_in) begin
      pattern = {SEG_DASH[7:1], ~eff_dp};
    end else begin
      pattern = {hex_pat[7:1], ~eff_dp};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q         <= '0;
      idx_q         <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      snap_nib_q    <= 4'h0;
      snap_dp_q     <= 1'b0;
      snap_blank_q  <= 1'b0;
      snap_blink_q  <= 1'b0;
      seg_out       <= SEG_OFF;
      an_out        <= '1;
    end else begin
      if (slot_end) begin
        cnt_q <= '0;
        idx_q <= (idx_q == IW'(N_DIGITS - 1)) ? '0 : idx_q + 1'b1;
        if (blink_cnt_q == BW'(BLINK_SLOTS - 1)) begin
          blink_cnt_q   <= '0;
          blink_phase_q <= ~blink_phase_q;
        end else begin
          blink_cnt_q <= blink_cnt_q + 1'b1;
        end
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end

      if (slot_start) begin
        snap_nib_q   <= cur_nib;
        snap_dp_q    <= cur_dp;
        snap_blank_q <= cur_blank;
        snap_blink_q <= cur_blink;
      end

      if (!en_in) begin
        seg_out <= SEG_OFF;
        an_out  <= '1;
      end else begin
        case (state)
          GAP: begin
            seg_out <= SEG_OFF;
            an_out  <= '1;
          end
          DRIVE: begin
            seg_out <= pattern;
            an_out  <= ~(N_DIGITS'(1) << idx_q);
          end
          default: begin
            seg_out <= SEG_OFF;
            an_out  <= '1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan.sv
// Directed self-checking bench for seg7_scan (4 digits, 4-cycle slots, 1-cycle gap, blink 2).
module tb_seg7_scan;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] digits_in;
  logic [3:0]  dp_in, blank_in, blink_in;
  logic        mask_in, en_in;
  logic [7:0]  seg_out;
  logic [3:0]  an_out;

  int n_vec = 0;
  int n_err = 0;
  int g;  // counter value reflected by the outputs at the current sample

  logic [7:0] tbl [16] = '{
    8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
    8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71
  };
  logic [7:0] scan_seg [4] = '{8'h99, 8'h0D, 8'h25, 8'h9F};  // digits 4,3,2,1
  logic [3:0] one = 4'b0001;
  logic [7:0] exp_seg;
  logic [3:0] exp_an;

  seg7_scan #(
    .N_DIGITS    (4),
    .CLK_DIV     (4),
    .GAP_CYCLES  (1),
    .BLINK_SLOTS (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .digits_in (digits_in),
    .dp_in     (dp_in),
    .blank_in  (blank_in),
    .blink_in  (blink_in),
    .mask_in   (mask_in),
    .en_in     (en_in),
    .seg_out   (seg_out),
    .an_out    (an_out)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: seg=%h an=%b required finish", seg_out, an_out);
    $fatal(1, "timeout");
  end

  task automatic step();
    @(negedge clk);
    g++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    g = -1;
  endtask

  task automatic step_to(input int target);
    while (g < target) step();
  endtask

  task automatic test_reset();
    digits_in = 16'h1234;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_vec++;
      if (seg_out !== 8'hFF || an_out !== 4'hF) begin
        n_err++;
        $display("FAIL reset[%0d]: seg=%h an=%b required seg=ff an=1111", i, seg_out, an_out);
      end
    end
    rst = 1'b0;
    g = -1;
    step();
    n_vec++;
    if (seg_out !== 8'hFF || an_out !== 4'hF) begin
      n_err++;
      $display("FAIL first_gap: seg=%h an=%b required seg=ff an=1111", seg_out, an_out);
    end
    step();
    n_vec++;
    if (seg_out !== 8'h99 || an_out !== 4'b1110) begin
      n_err++;
      $display("FAIL first_drive: seg=%h an=%b required seg=99 an=1110", seg_out, an_out);
    end
  endtask

  task automatic test_scan();
    do_reset();
    for (int i = 0; i < 36; i++) begin
      step();
      exp_an  = (g % 4 == 0) ? 4'hF : ~(one << ((g / 4) % 4));
      exp_seg = (g % 4 == 0) ? 8'hFF : scan_seg[(g / 4) % 4];
      n_vec++;
      if (seg_out !== exp_seg || an_out !== exp_an) begin
        n_err++;
        $display("FAIL scan g=%0d: seg=%h an=%b required seg=%h an=%b",
                 g, seg_out, an_out, exp_seg, exp_an);
      end
    end
  endtask

  task automatic test_hex_sweep();
    digits_in = 16'h1230;
    do_reset();
    for (int v = 0; v < 16; v++) begin
      digits_in[3:0] = 4'(v);
      for (int k = 0; k < 20 && (g < 1 || g % 16 != 1); k++) step();
      n_vec++;
      if (seg_out !== tbl[v] || an_out !== 4'b1110) begin
        n_err++;
        $display("FAIL hex %0h: seg=%h an=%b required seg=%h an=1110", v, seg_out, an_out, tbl[v]);
      end
      step();
    end
    digits_in = 16'h1234;
  endtask

  task automatic test_dp_blank_mask();
    dp_in    = 4'b0001;
    blank_in = 4'b0010;
    do_reset();
    step_to(1);
    n_vec++;
    if (seg_out !== 8'h98 || an_out !== 4'b1110) begin
      n_err++;
      $display("FAIL dp: seg=%h an=%b required seg=98 an=1110", seg_out, an_out);
    end
    step_to(5);
    n_vec++;
    if (seg_out !== 8'hFF || an_out !== 4'b1101) begin
      n_err++;
      $display("FAIL blank: seg=%h an=%b required seg=ff an=1101", seg_out, an_out);
    end
    mask_in = 1'b1;
    step_to(9);
    n_vec++;
    if (seg_out !== 8'hFD || an_out !== 4'b1011) begin
      n_err++;
      $display("FAIL mask_d2: seg=%h an=%b required seg=fd an=1011", seg_out, an_out);
    end
    step_to(17);
    n_vec++;
    if (seg_out !== 8'hFC || an_out !== 4'b1110) begin
      n_err++;
      $display("FAIL mask_dp: seg=%h an=%b required seg=fc an=1110", seg_out, an_out);
    end
    step_to(21);
    n_vec++;
    if (seg_out !== 8'hFF || an_out !== 4'b1101) begin
      n_err++;
      $display("FAIL mask_blank: seg=%h an=%b required seg=ff an=1101", seg_out, an_out);
    end
    mask_in  = 1'b0;
    dp_in    = 4'b0000;
    blank_in = 4'b0000;
  endtask

  task automatic test_blink();
    blink_in = 4'b1111;
    do_reset();
    for (int i = 0; i < 32; i++) begin
      step();
      if (g % 4 != 0) begin
        exp_an  = ~(one << ((g / 4) % 4));
        exp_seg = (((g / 4) / 2) % 2 == 1) ? 8'hFF : scan_seg[(g / 4) % 4];
        n_vec++;
        if (seg_out !== exp_seg || an_out !== exp_an) begin
          n_err++;
          $display("FAIL blink_all g=%0d: seg=%h an=%b required seg=%h an=%b",
                   g, seg_out, an_out, exp_seg, exp_an);
        end
      end
    end
    blink_in = 4'b0100;
    do_reset();
    step_to(1);
    n_vec++;
    if (seg_out !== 8'h99) begin
      n_err++;
      $display("FAIL blink_d0_steady: seg=%h required seg=99", seg_out);
    end
    step_to(9);
    n_vec++;
    if (seg_out !== 8'hFF || an_out !== 4'b1011) begin
      n_err++;
      $display("FAIL blink_d2_off: seg=%h an=%b required seg=ff an=1011", seg_out, an_out);
    end
    blink_in = 4'b0000;
  endtask

  task automatic test_midslot_change();
    do_reset();
    step_to(1);
    digits_in = 16'h1238;
    for (int i = 0; i < 2; i++) begin
      step();
      n_vec++;
      if (seg_out !== 8'h99) begin
        n_err++;
        $display("FAIL midslot_hold g=%0d: seg=%h required seg=99", g, seg_out);
      end
    end
    step_to(5);
    n_vec++;
    if (seg_out !== 8'h0D) begin
      n_err++;
      $display("FAIL midslot_d1: seg=%h required seg=0d", seg_out);
    end
    step_to(17);
    n_vec++;
    if (seg_out !== 8'h01 || an_out !== 4'b1110) begin
      n_err++;
      $display("FAIL midslot_next: seg=%h an=%b required seg=01 an=1110", seg_out, an_out);
    end
    digits_in = 16'h1234;
  endtask

  task automatic test_enable();
    do_reset();
    step_to(5);
    en_in = 1'b0;
    step();
    n_vec++;
    if (seg_out !== 8'hFF || an_out !== 4'hF) begin
      n_err++;
      $display("FAIL en_off: seg=%h an=%b required seg=ff an=1111", seg_out, an_out);
    end
    en_in = 1'b1;
    step();
    n_vec++;
    if (seg_out !== 8'h0D || an_out !== 4'b1101) begin
      n_err++;
      $display("FAIL en_on: seg=%h an=%b required seg=0d an=1101", seg_out, an_out);
    end
  endtask

  task automatic test_rst_midslot();
    do_reset();
    step_to(9);  // counter now at count 2 of digit 2
    n_vec++;
    if (seg_out !== 8'h25 || an_out !== 4'b1011) begin
      n_err++;
      $display("FAIL pre_rst: seg=%h an=%b required seg=25 an=1011", seg_out, an_out);
    end
    rst = 1'b1;
    @(negedge clk);
    n_vec++;
    if (seg_out !== 8'hFF || an_out !== 4'hF) begin
      n_err++;
      $display("FAIL rst_mid_dark: seg=%h an=%b required seg=ff an=1111", seg_out, an_out);
    end
    rst = 1'b0;
    g = -1;
    step_to(1);
    n_vec++;
    if (seg_out !== 8'h99 || an_out !== 4'b1110) begin
      n_err++;
      $display("FAIL rst_restart: seg=%h an=%b required seg=99 an=1110", seg_out, an_out);
    end
  endtask

  initial begin
    rst       = 1'b1;
    digits_in = 16'h1234;
    dp_in     = 4'b0000;
    blank_in  = 4'b0000;
    blink_in  = 4'b0000;
    mask_in   = 1'b0;
    en_in     = 1'b1;
    g         = -1;
    test_reset();
    test_scan();
    test_hex_sweep();
    test_dp_blank_mask();
    test_blink();
    test_midslot_change();
    test_enable();
    test_rst_midslot();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
